// File: rtl/vga_frame_capture.sv
// vga_frame_capture: packs one frame of 4-bit pixels into 32-bit words written through a valid/ready port
module vga_frame_capture #(
  parameter int HOR_PXL    = 800,
  parameter int VER_PXL    = 600,
  parameter int VSYNC_POL  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_WORDS  = HOR_PXL * VER_PXL / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_word,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [3:0]            color_number,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  short_frame
);
  localparam int TOTAL = HOR_PXL * VER_PXL;
  localparam int CW = $clog2(TOTAL);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [ADDR_WIDTH:0] MW = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic VP = 1'(VSYNC_POL);
  typedef enum logic [2:0] {IDLE, WAIT_VSYNC, CAPTURE, DRAIN, DONE} state_t;
  state_t state;
  logic vsync_q, vedge, push, pop, empty, full, arm;
  logic [CW-1:0] pix_cnt;
  logic [27:0] sr;
  logic [ADDR_WIDTH-1:0] base, word_idx, push_addr;
  logic [ADDR_WIDTH:0] sum;
  logic [PW:0] wp, rp;
  logic [ADDR_WIDTH+31:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH+31:0] head;
  assign vedge = (vsync_q != VP) && (vsync == VP);
  assign arm = start && !abort && (state == IDLE || state == DONE);
  assign push = state == CAPTURE && !abort && !vedge && de && &pix_cnt[2:0];
  assign sum = {1'b0, base} + {1'b0, word_idx};
  assign push_addr = ADDR_WIDTH'(sum >= MW ? sum - MW : sum);
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign pop = wr_valid && wr_ready;
  assign head = mem[rp[PW-1:0]];
  assign wr_valid = !empty;
  assign wr_addr = empty ? '0 : head[ADDR_WIDTH+31:32];
  assign wr_data = empty ? '0 : head[31:0];
  // capture FSM: sync detection, pixel shifting, counters and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vsync_q <= VP;
      busy <= 1'b0;
      done <= 1'b0;
      short_frame <= 1'b0;
      pix_cnt <= '0;
      word_idx <= '0;
      sr <= '0;
      base <= '0;
    end else begin
      vsync_q <= vsync;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b0;
      end else case (state)
        IDLE, DONE: if (start) begin
          state <= WAIT_VSYNC;
          busy <= 1'b1;
          done <= 1'b0;
          base <= base_word;
          pix_cnt <= '0;
          word_idx <= '0;
          short_frame <= 1'b0;
        end
        WAIT_VSYNC: if (vedge) state <= CAPTURE;
        CAPTURE: if (vedge) begin
          short_frame <= 1'b1;
          state <= DRAIN;
        end else if (de) begin
          pix_cnt <= pix_cnt + 1'b1;
          sr <= {color_number, sr[27:4]};
          if (&pix_cnt[2:0]) word_idx <= word_idx + 1'b1;
          if (pix_cnt == LAST) state <= DRAIN;
        end
        DRAIN: if (empty) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // fifo pointers and drop detection; a full fifo that is also popping still accepts the word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (pop) rp <= rp + 1'b1;
      if (push && (!full || pop)) wp <= wp + 1'b1;
      overflow <= arm ? 1'b0 : overflow | (push && full && !pop);
    end
  end
  // fifo storage, written only when the word is accepted
  always_ff @(posedge clk) begin
    if (push && (!full || pop)) mem[wp[PW-1:0]] <= {push_addr, color_number, sr};
  end
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed checks of frame packing, wrap, overflow, short frame, abort and reset
module tb_vga_frame_capture;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, vsync = 0, de = 0, wr_ready = 0;
  logic [15:0] base_word = 0;
  logic [3:0] color_number = 0;
  logic wr_valid, busy, done, overflow, short_frame;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  int checks = 0, failures = 0;
  logic [15:0] wa [$];
  logic [31:0] wd [$];
  vga_frame_capture #(.HOR_PXL(16), .VER_PXL(2), .VSYNC_POL(1), .FIFO_DEPTH(2), .ADDR_WIDTH(16), .MEM_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_word(base_word),
    .vsync(vsync), .de(de), .color_number(color_number), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow),
    .short_frame(short_frame)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_valid && wr_ready) begin
    wa.push_back(wr_addr);
    wd.push_back(wr_data);
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic arm(input logic [15:0] b);
    base_word = b;
    start = 1;
    step();
    start = 0;
    vsync = 1;
    step();
    vsync = 0;
  endtask
  task automatic pixels(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      de = 1;
      color_number = 4'((first + i) % 16);
      step();
    end
    de = 0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk(tag, {31'b0, done}, 1);
  endtask
  task automatic chk_writes(input string tag, input int n, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [15:0] a3);
    logic [15:0] ea [4];
    logic [31:0] ed [4];
    ea = '{a0, a1, a2, a3};
    ed = '{32'h76543210, 32'hFEDCBA98, 32'h76543210, 32'hFEDCBA98};
    chk({tag, "_count"}, wa.size(), n);
    for (int i = 0; i < n; i++) if (i < wa.size()) begin
      chk($sformatf("%s_addr%0d", tag, i), {16'b0, wa[i]}, {16'b0, ea[i]});
      chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
    end
    wa.delete();
    wd.delete();
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_outs"}, {25'b0, wr_valid, busy, done, overflow, short_frame, 2'b0}, 0);
    chk({tag, "_addr"}, {16'b0, wr_addr}, 0);
    chk({tag, "_data"}, wr_data, 0);
  endtask
  initial begin
    step();
    step();
    chk_idle_outs("reset");
    rst_n = 1;
    step();
    wr_ready = 1;
    arm(0);
    chk("t1_busy", {31'b0, busy}, 1);
    pixels(32, 0);
    wait_done("t1_done");
    chk("t1_busy_end", {31'b0, busy}, 0);
    chk_writes("t1", 4, 0, 1, 2, 3);
    arm(3);
    pixels(32, 0);
    wait_done("t2_done");
    chk_writes("t2", 4, 3, 0, 1, 2);
    wr_ready = 0;
    arm(0);
    pixels(12, 0);
    chk("t3_head_valid", {31'b0, wr_valid}, 1);
    chk("t3_head_addr", {16'b0, wr_addr}, 0);
    chk("t3_head_data", wr_data, 32'h76543210);
    pixels(20, 12);
    chk("t3_hold_addr", {16'b0, wr_addr}, 0);
    chk("t3_hold_data", wr_data, 32'h76543210);
    chk("t3_overflow", {31'b0, overflow}, 1);
    chk("t3_not_done", {30'b0, busy, done}, 2);
    wr_ready = 1;
    wait_done("t3_done");
    chk_writes("t3", 2, 0, 1, 0, 0);
    arm(0);
    chk("t4_ovf_cleared", {31'b0, overflow}, 0);
    pixels(12, 0);
    vsync = 1;
    step();
    vsync = 0;
    wait_done("t4_done");
    chk("t4_short", {31'b0, short_frame}, 1);
    chk_writes("t4", 1, 0, 0, 0, 0);
    wr_ready = 0;
    arm(0);
    chk("t5_short_cleared", {31'b0, short_frame}, 0);
    pixels(10, 0);
    chk("t5_pending", {31'b0, wr_valid}, 1);
    abort = 1;
    start = 1;
    step();
    abort = 0;
    start = 0;
    chk("t5_abort", {29'b0, wr_valid, busy, done}, 0);
    wr_ready = 1;
    pixels(20, 10);
    chk("t5_no_writes", wa.size(), 0);
    arm(1);
    pixels(32, 0);
    wait_done("t5_done");
    chk("t5_flags", {30'b0, overflow, short_frame}, 0);
    chk_writes("t5", 4, 1, 2, 3, 0);
    wr_ready = 0;
    arm(0);
    pixels(10, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    chk_idle_outs("t6_reset");
    wr_ready = 1;
    pixels(16, 0);
    chk("t6_no_writes", wa.size(), 0);
    base_word = 0;
    start = 1;
    step();
    base_word = 2;
    step();
    start = 0;
    vsync = 1;
    step();
    vsync = 0;
    pixels(32, 0);
    wait_done("t6_done");
    chk_writes("t6", 4, 0, 1, 2, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receiver end of the VGA pixel interface: samples a pixel stream (hsync/vsync/de plus a 4-bit color number) and packs one full frame into graphics-memory words.
- Packing is 8 pixels per 32-bit word, little-endian: pixel k of a word occupies bits [4k+3:4k].
- Words are written through a valid/ready write port into the graphics memory, wrapping at the frame size from a programmable base word.
- Used for loopback verification of the display path and for frame grabbing into the framebuffer.

Parameters:
HOR_PXL, 800, visible pixels per line
VER_PXL, 600, visible lines per frame
VSYNC_POL, 1, active level of vsync
FIFO_DEPTH, 4, packed-word buffer depth (power of 2, >=2)
ADDR_WIDTH, 16, word address width
MEM_WORDS, HOR_PXL*VER_PXL/8, frame size in words; also the wrap modulus

Ports:
clk  in  1  pixel clock; the only clock
rst_n  in  1  synchronous reset, active low
start  in  1  one-cycle pulse: arm capture of the next frame
abort  in  1  one-cycle pulse: cancel capture, flush buffer
base_word  in  ADDR_WIDTH  first word address of the frame; sampled on accepted start; must be < MEM_WORDS
vsync  in  1  vertical sync from the pixel source
de  in  1  data enable; the pixel is valid when high
color_number  in  4  pixel color index
wr_valid  out  1  write request
wr_ready  in  1  memory accepts the write
wr_addr  out  ADDR_WIDTH  word address
wr_data  out  32  packed pixels
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE
overflow  out  1  sticky: a packed word was dropped
short_frame  out  1  sticky: vsync began before the frame was complete

Behaviour:
- Reset (rst_n low at posedge clk): state=IDLE, FIFO empty, pixel/word counters 0, shift register 0.
  Outputs after reset: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, short_frame=0.
- Reset asserted mid-operation discards everything; no further writes are issued.
- States and transitions:
  - IDLE: start -> WAIT_VSYNC. On entry via start: latch base_word, clear counters, clear overflow and short_frame.
  - WAIT_VSYNC: wait for a vsync active edge (previous sample != VSYNC_POL, current sample == VSYNC_POL) -> CAPTURE.
  - CAPTURE: each cycle with de=1 shifts color_number into pixel slot (pix_cnt mod 8).
    - On slot 7, the completed word is pushed with address (base + word_idx) mod MEM_WORDS, and word_idx increments.
    - When pix_cnt reaches HOR_PXL*VER_PXL-1 and is sampled -> DRAIN.
    - A vsync active edge in CAPTURE -> short_frame=1, partial word discarded, -> DRAIN.
  - DRAIN: FIFO empty -> DONE.
  - DONE: holds done=1; start -> WAIT_VSYNC (re-arm with the same side effects as from IDLE).
  - abort in any state -> IDLE next cycle: FIFO flushed, wr_valid=0, done=0; sticky flags retained.
  - abort and start in the same cycle: abort wins.
  - start in WAIT_VSYNC, CAPTURE or DRAIN is ignored.
- Address arithmetic: sum = base + word_idx, computed at ADDR_WIDTH+1 bits; subtract MEM_WORDS once if sum >= MEM_WORDS. No modulo operator.
- FIFO:
  - Show-ahead; wr_valid = !empty; wr_addr/wr_data come from the head entry.
  - Transfer occurs on a cycle with wr_valid && wr_ready. Head must stay stable while wr_valid && !wr_ready.
  - Push and pop in the same cycle are both allowed at full or empty.
  - Push when full and not popping: the word is dropped, overflow=1, and word_idx still increments so later addresses stay correct.
  - Drop does not affect state.
- Latency: the word completed at posedge N has wr_valid=1 after posedge N if the FIFO was empty before it. Minimum pixel-to-write latency is 1 cycle.
- de=0 cycles (blanking) do not advance counters. hsync is not used.

Test Plan:
- Params HOR_PXL=16, VER_PXL=2, MEM_WORDS=4, base_word=0, wr_ready=1, pixels 0..F repeating. start, vsync edge, 32 de pixels -> 4 writes, addr 0..3, data 0x76543210, 0xFEDCBA98 (x2 pattern), then done=1, busy=0.
- Same stream, base_word=3 -> addresses 3,0,1,2 (wrap), data order unchanged.
- wr_ready=0 throughout capture, FIFO_DEPTH=2 -> first 2 words held stable, words 3-4 dropped, overflow=1. Release ready -> writes at addr 0,1 only, then DONE.
- vsync edge after 12 pixels of capture -> short_frame=1, one write (addr 0), partial word discarded, DONE.
- abort during CAPTURE with 1 word pending, wr_ready=0 -> next cycle wr_valid=0, state IDLE, no later writes; a following start restarts cleanly with flags cleared.
- rst_n low for 1 cycle mid-CAPTURE -> all outputs 0 next cycle; start asserted while busy is ignored (base_word change has no effect).
